// File: rtl/ifetch_unit_if.sv
// Instruction-memory request/response bus between ifetch_unit (master) and the memory (slave).
interface ifetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req, imem_addr,
    input  imem_gnt, imem_rvalid, imem_rdata
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_gnt, imem_rvalid, imem_rdata
  );
endinterface

// File: rtl/ifetch_unit.sv
// Instruction fetch: one-outstanding request FSM feeding a 2-entry instruction FIFO.
// Optional retired-fetch counter (fetch_cnt) enabled by defining IFETCH_PERF_CNT_EN.
module ifetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [31:0]         npc,
  input  logic                redirect,
  ifetch_unit_if.master       bus,
  output logic                inst_valid,
  output logic [31:0]         inst,
  output logic [31:0]         inst_pc,
  input  logic                inst_ready,
  output logic [31:0]         pc
`ifdef IFETCH_PERF_CNT_EN
  ,
  output logic [31:0]         fetch_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] word;
  } entry_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q;
  logic        drop_q, drop_d;
  entry_t      fifo_q [2];
  logic        rd_ptr_q, wr_ptr_q;
  logic [1:0]  count_q, count_after;

  logic granted, push, pop, space;

  // A redirect discards everything in flight, including a same-cycle pop or response.
  assign granted     = (state_q == REQ) && bus.imem_gnt;
  assign push        = (state_q == WAIT) && bus.imem_rvalid && !drop_q && !redirect;
  assign pop         = (count_q != 2'd0) && inst_ready && !redirect;
  assign count_after = count_q + 2'(push) - 2'(pop);
  assign space       = (count_after < 2'd2);

  // NOTE: every variable gets a default before the case so no latch is inferred.
  always_comb begin
    state_d = state_q;
    drop_d  = drop_q;
    if (redirect) begin
      if (granted || (state_q == WAIT && !bus.imem_rvalid)) begin
        state_d = WAIT;
        drop_d  = 1'b1;
      end else begin
        state_d = REQ;
        drop_d  = 1'b0;
      end
    end else begin
      case (state_q)
        IDLE: if (space) state_d = REQ;
        REQ:  if (bus.imem_gnt) state_d = WAIT;
        WAIT: if (bus.imem_rvalid) begin
                drop_d  = 1'b0;
                state_d = space ? REQ : IDLE;
              end
        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: state is updated with non-blocking assignments so all flops sample the same pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      drop_q  <= 1'b0;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      drop_q  <= drop_d;
      if (redirect)     pc_q <= npc;
      else if (granted) pc_q <= pc_q + 32'd4;
    end
  end

  // NOTE: the two FIFO entries are reset because inst/inst_pc must read zero out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fifo_q[0] <= '0;
      fifo_q[1] <= '0;
      rd_ptr_q  <= 1'b0;
      wr_ptr_q  <= 1'b0;
      count_q   <= 2'd0;
    end else if (redirect) begin
      rd_ptr_q  <= 1'b0;
      wr_ptr_q  <= 1'b0;
      count_q   <= 2'd0;
    end else begin
      // A kept response always belongs to the last grant, so its address is pc - 4.
      if (push) begin
        fifo_q[wr_ptr_q] <= '{addr: pc_q - 32'd4, word: bus.imem_rdata};
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_after;
    end
  end

`ifdef IFETCH_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)      fetch_cnt <= 32'd0;
    else if (pop) fetch_cnt <= fetch_cnt + 32'd1;
  end
`endif

  assign bus.imem_req  = (state_q == REQ);
  assign bus.imem_addr = pc_q;
  assign pc            = pc_q;
  assign inst_valid    = (count_q != 2'd0);
  assign inst          = fifo_q[rd_ptr_q].word;
  assign inst_pc       = fifo_q[rd_ptr_q].addr;

endmodule

// File: tb/tb_ifetch_unit.sv
// Randomized bench for ifetch_unit: memory responder plus an in-order program-counter stream model.
module tb_ifetch_unit;

  logic        clk = 1'b0;
  logic        rst, rst1;
  logic [31:0] npc, npc1;
  logic        redirect, redirect1;
  logic        inst_valid, inst_valid1;
  logic [31:0] inst, inst1, inst_pc, inst_pc1, pc, pc1;
  logic        inst_ready, inst_ready1;
`ifdef IFETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt, fetch_cnt1;
`endif

  ifetch_unit_if bus0 ();
  ifetch_unit_if bus1 ();

  always #5 clk = ~clk;

  ifetch_unit dut (
    .clk        (clk),
    .rst        (rst),
    .npc        (npc),
    .redirect   (redirect),
    .bus        (bus0),
    .inst_valid (inst_valid),
    .inst       (inst),
    .inst_pc    (inst_pc),
    .inst_ready (inst_ready),
    .pc         (pc)
`ifdef IFETCH_PERF_CNT_EN
    ,
    .fetch_cnt  (fetch_cnt)
`endif
  );

  ifetch_unit #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
    .clk        (clk),
    .rst        (rst1),
    .npc        (npc1),
    .redirect   (redirect1),
    .bus        (bus1),
    .inst_valid (inst_valid1),
    .inst       (inst1),
    .inst_pc    (inst_pc1),
    .inst_ready (inst_ready1),
    .pc         (pc1)
`ifdef IFETCH_PERF_CNT_EN
    ,
    .fetch_cnt  (fetch_cnt1)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Stimulus knobs (percentages) and memory-model state
  int          gnt_prob, ready_prob, redir_prob, dly_min, dly_max;
  logic        redir_force;
  logic [31:0] force_npc;
  logic        pend, req_waiting, last_redir;
  logic [31:0] pend_addr, last_addr;
  int          pend_dly;
  int          n_gnt, pops;
  logic [31:0] exp_pc;
  logic [31:0] mem_seed;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    return (addr * 32'h9E37_79B9) ^ mem_seed;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    redirect = 1'b0; npc = 32'd0; inst_ready = 1'b0;
    bus0.imem_gnt = 1'b0; bus0.imem_rvalid = 1'b0; bus0.imem_rdata = 32'd0;
    pend = 1'b0; req_waiting = 1'b0; last_redir = 1'b0; redir_force = 1'b0;
    @(posedge clk); #1;
    check("rst_imem_req",   {31'd0, bus0.imem_req}, 32'd0);
    check("rst_imem_addr",  bus0.imem_addr, 32'd0);
    check("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
    check("rst_inst",       inst, 32'd0);
    check("rst_inst_pc",    inst_pc, 32'd0);
    check("rst_pc",         pc, 32'd0);
`ifdef IFETCH_PERF_CNT_EN
    check("rst_fetch_cnt",  fetch_cnt, 32'd0);
`endif
    rst = 1'b0;
    exp_pc = 32'd0; pops = 0; n_gnt = 0;
  endtask

  // Decide inputs for the next edge from the settled outputs, predict that edge, then advance.
  task automatic cycle();
    logic        do_redir, pend_at_entry;
    logic [31:0] n;
    do_redir    = redir_force || ($urandom_range(99) < redir_prob);
    n           = redir_force ? force_npc : $urandom();
    redir_force = 1'b0;
    redirect    = do_redir;
    npc         = n;
    inst_ready  = ($urandom_range(99) < ready_prob);

    if (inst_valid && inst_ready && !do_redir) begin
      check("pop_inst_pc", inst_pc, exp_pc);
      check("pop_inst",    inst, mem_word(exp_pc));
      exp_pc += 32'd4;
      pops++;
    end
    if (do_redir) exp_pc = n;

    pend_at_entry     = pend;
    bus0.imem_rvalid  = 1'b0;
    bus0.imem_rdata   = $urandom();
    if (pend) begin
      if (pend_dly == 0) begin
        bus0.imem_rvalid = 1'b1;
        bus0.imem_rdata  = mem_word(pend_addr);
        pend             = 1'b0;
      end else begin
        pend_dly--;
      end
    end

    if (bus0.imem_req) begin
      check("one_outstanding", {31'd0, pend_at_entry}, 32'd0);
      if (req_waiting && !last_redir) check("addr_stable", bus0.imem_addr, last_addr);
      bus0.imem_gnt = ($urandom_range(99) < gnt_prob);
      if (bus0.imem_gnt) begin
        pend      = 1'b1;
        pend_addr = bus0.imem_addr;
        pend_dly  = $urandom_range(dly_max, dly_min);
        n_gnt++;
      end
      req_waiting = !bus0.imem_gnt;
      last_addr   = bus0.imem_addr;
    end else begin
      bus0.imem_gnt = 1'($urandom_range(1));
      req_waiting   = 1'b0;
    end
    last_redir = do_redir;
    @(posedge clk); #1;
  endtask

  task automatic wait_req(input string tag);
    int budget = 20;
    while (!bus0.imem_req && budget > 0) begin
      cycle();
      budget--;
    end
    if (!bus0.imem_req) check(tag, 32'd0, 32'd1);
  endtask

  task automatic set_knobs(input int g, input int r, input int d, input int dmin, input int dmax);
    gnt_prob = g; ready_prob = r; redir_prob = d; dly_min = dmin; dly_max = dmax;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        g1;
    logic [31:0] g1_addr, exp1;
    int          pops1;

    mem_seed = $urandom();
    rst1 = 1'b1; redirect1 = 1'b0; npc1 = 32'd0; inst_ready1 = 1'b0;
    bus1.imem_gnt = 1'b0; bus1.imem_rvalid = 1'b0; bus1.imem_rdata = 32'd0;

    // Streaming with an always-granting, next-cycle memory and a ready consumer
    set_knobs(100, 100, 0, 0, 0);
    do_reset();
    repeat (30) cycle();
    check("stream_progress", {31'd0, pops >= 10}, 32'd1);
`ifdef IFETCH_PERF_CNT_EN
    check("stream_fetch_cnt", fetch_cnt, pops);
`endif

    // Stalled consumer: exactly two fetches fill the FIFO, then the fetcher idles
    set_knobs(100, 0, 0, 0, 0);
    do_reset();
    repeat (10) cycle();
    check("stall_grants",   n_gnt, 32'd2);
    check("stall_valid",    {31'd0, inst_valid}, 32'd1);
    check("stall_inst_pc",  inst_pc, 32'd0);
    check("stall_no_req",   {31'd0, bus0.imem_req}, 32'd0);
    ready_prob = 100;
    cycle();
    ready_prob = 0;
    check("refill_req",     {31'd0, bus0.imem_req}, 32'd1);
    check("refill_addr",    bus0.imem_addr, 32'h8);

    // Grant withheld for three cycles on the second request
    set_knobs(100, 100, 0, 0, 0);
    do_reset();
    wait_req("gnt_wait_req0");
    cycle();
    gnt_prob = 0;
    wait_req("gnt_wait_req1");
    for (int i = 0; i < 3; i++) begin
      check("held_req",  {31'd0, bus0.imem_req}, 32'd1);
      check("held_addr", bus0.imem_addr, 32'h4);
      check("held_pc",   pc, 32'h4);
      cycle();
    end
    gnt_prob = 100;
    cycle();
    check("granted_pc", pc, 32'h8);

    // Redirect while a request is outstanding: stale response dropped
    set_knobs(100, 100, 0, 3, 3);
    do_reset();
    wait_req("redir_wait_req0");
    cycle();
    redir_force = 1'b1;
    force_npc   = 32'h100;
    cycle();
    check("redir_empty",  {31'd0, inst_valid}, 32'd0);
    check("redir_no_req", {31'd0, bus0.imem_req}, 32'd0);
    check("redir_pc",     pc, 32'h100);
    wait_req("redir_wait_req1");
    check("redir_addr",   bus0.imem_addr, 32'h100);
    dly_min = 0; dly_max = 0;
    pops = 0;
    repeat (12) cycle();
    check("redir_progress", {31'd0, pops >= 1}, 32'd1);

    // Randomized segments with varying grant/ready/redirect pressure
    for (int s = 0; s < 4; s++) begin
      case (s)
        0:       set_knobs(50, 50, 5, 0, 3);
        1:       set_knobs(90, 30, 2, 1, 4);
        2:       set_knobs(30, 90, 10, 0, 1);
        default: set_knobs(70, 70, 20, 0, 5);
      endcase
      do_reset();
      repeat (700) cycle();
      check("random_progress", {31'd0, pops > 0}, 32'd1);
    end
    set_knobs(0, 0, 0, 0, 0);
    redirect = 1'b0;

    // Address wrap from a high reset PC
    @(posedge clk); #1;
    check("wrap_rst_addr", bus1.imem_addr, 32'hFFFF_FFF8);
    check("wrap_rst_pc",   pc1, 32'hFFFF_FFF8);
    rst1 = 1'b0;
    exp1 = 32'hFFFF_FFF8; pops1 = 0; g1 = 1'b0; g1_addr = 32'd0;
    for (int c = 0; c < 40 && pops1 < 3; c++) begin
      inst_ready1       = 1'b1;
      bus1.imem_rvalid  = g1;
      bus1.imem_rdata   = g1 ? mem_word(g1_addr) : 32'd0;
      g1                = bus1.imem_req;
      g1_addr           = bus1.imem_addr;
      bus1.imem_gnt     = 1'b1;
      if (inst_valid1) begin
        check("wrap_inst_pc", inst_pc1, exp1);
        check("wrap_inst",    inst1, mem_word(exp1));
        exp1 += 32'd4;
        pops1++;
      end
      @(posedge clk); #1;
    end
    inst_ready1 = 1'b0;
    bus1.imem_gnt = 1'b0;
    bus1.imem_rvalid = 1'b0;
    check("wrap_pops", pops1, 32'd3);
`ifdef IFETCH_PERF_CNT_EN
    check("wrap_fetch_cnt", fetch_cnt1, 32'd3);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
